// File: rtl/br_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: flush window, RAT restore pulse, frontend redirect, one-cycle drain.
// Optional perf counters are built only when BR_PERF_CNT_EN is defined.
module br_recovery_ctrl #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic            commit_is_ctrl,
  input  logic            commit_mispredict,
  input  logic [PC_W-1:0] commit_target,
  output logic            commit_stall,
  output logic            backend_flush,
  output logic            rat_restore,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic [31:0]     perf_br_cnt,
  output logic [31:0]     perf_mp_cnt,
  output logic [1:0]      fsm_state
);

  // Redirect handshake: redirect_valid rises in REDIRECT and stays high with a
  // stable redirect_pc until the first cycle redirect_ready is also high.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ctrl_commit;
  logic            trigger;

  assign ctrl_commit = commit_valid & commit_is_ctrl;
  assign trigger     = ctrl_commit & commit_mispredict;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
          pc_d    = commit_target;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs decode only registered state, so nothing combinational reaches them from inputs.
  assign commit_stall   = (state_q != IDLE);
  assign backend_flush  = (state_q == FLUSH);
  assign rat_restore    = (state_q == FLUSH) && (cnt_q == CNT_INIT);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = pc_q;
  assign fsm_state      = state_q;

`ifdef BR_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  // Mispredicts count only when they actually start a recovery.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt_q <= 32'd0;
      mp_cnt_q <= 32'd0;
    end else begin
      if (ctrl_commit) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (trigger && (state_q == IDLE)) begin
        mp_cnt_q <= mp_cnt_q + 32'd1;
      end
    end
  end

  assign perf_br_cnt = br_cnt_q;
  assign perf_mp_cnt = mp_cnt_q;
`else
  assign perf_br_cnt = 32'd0;
  assign perf_mp_cnt = 32'd0;
`endif

endmodule

// File: doc/br_recovery_ctrl.md
# br_recovery_ctrl

Sequences branch-mispredict recovery in the backend. It watches the ROB commit port for a mispredicted control instruction, then drives the backend flush for a fixed window and pulses the RAT/free-list restore. It hands the corrected PC to the frontend over a valid/ready handshake and stalls ROB commit until recovery completes. It sits between the ROB commit stage, the branch unit/control buffer (the consumers of `backend_flush`) and the fetch redirect path.

## Interface
Parameters:
- `PC_W`, default 32: PC / target width.
- `FLUSH_CYCLES`, default 2: cycles `backend_flush` is held; legal range 1..15.

Ports:
- `clk`, in, 1: the single clock for the block.
- `rst`, in, 1: synchronous, active-low reset.
- `commit_valid`, in, 1: ROB head commits this cycle.
- `commit_is_ctrl`, in, 1: committing uop is a branch/jump.
- `commit_mispredict`, in, 1: committing control uop was mispredicted.
- `commit_target`, in, PC_W: architecturally correct next PC.
- `commit_stall`, out, 1: ROB must not commit while high.
- `backend_flush`, out, 1: flush for ROB, RS, control buffer and FUs.
- `rat_restore`, out, 1: one-cycle pulse; RAT copies RRAT, free list rebuilds.
- `redirect_valid`, out, 1: redirect request to the frontend.
- `redirect_pc`, out, PC_W: redirect target.
- `redirect_ready`, in, 1: frontend accepts the redirect.
- `perf_br_cnt`, out, 32: committed control uops (feature-gated).
- `perf_mp_cnt`, out, 32: committed mispredicts (feature-gated).

## Operation
- A trigger is `commit_valid && commit_is_ctrl && commit_mispredict` in IDLE.
- FSM states:
  - IDLE: all outputs low. On a trigger, latch `commit_target` into `redirect_pc`, load the flush counter with `FLUSH_CYCLES-1`, and go to FLUSH.
  - FLUSH: `backend_flush=1` and `commit_stall=1`. `rat_restore=1` on the first FLUSH cycle only. The counter decrements each cycle; when it reads 0, go to REDIRECT.
  - REDIRECT: `redirect_valid=1` and `commit_stall=1`, with `redirect_pc` held stable. On `redirect_ready`, go to DRAIN.
  - DRAIN: `commit_stall=1` for exactly one cycle so the ROB head re-reads post-flush state, then go to IDLE.
- All outputs are registered, decoded from the state and counter registers.
- `redirect_pc` changes only on a trigger in IDLE.
- Handshake rules:
  - `redirect_valid` never drops before acceptance.
  - `redirect_ready` may be high before `redirect_valid`; the transfer occurs in the first cycle both are high.
- Boundary conditions:
  - A trigger outside IDLE is ignored. It is illegal, because `commit_stall` is high; the bench flags it as an error.
  - A correctly predicted control commit does not trigger.
  - A non-control commit with `commit_mispredict=1` does not trigger.
  - Reset in any state returns to IDLE next edge; the flush counter and `redirect_pc` clear to 0.

## Timing
- Reset values: every output is 0, including `redirect_pc` and both perf counters.
- Trigger at edge T gives:
  - `backend_flush` high cycles T+1 .. T+FLUSH_CYCLES.
  - `rat_restore` high cycle T+1 only.
  - `redirect_valid` high from T+FLUSH_CYCLES+1.
- Redirect accepted at cycle R gives DRAIN at R+1 and IDLE at R+2.
- `commit_stall` is high T+1 .. R+1.
- Minimum recovery, with `redirect_ready` tied high: FLUSH_CYCLES+2 cycles of stall.
- No combinational input-to-output paths.

## Configuration
- `BR_PERF_CNT_EN` defined:
  - `perf_br_cnt` increments on every `commit_valid && commit_is_ctrl`.
  - `perf_mp_cnt` increments on every trigger.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- `BR_PERF_CNT_EN` undefined: no counter flops; both outputs are tied to 0. FSM behaviour is identical.

## Test plan
- Reset then idle:
  - Hold `rst=0` 3 cycles, release, drive no commits.
  - Expect all outputs 0 for 20 cycles.
- Basic mispredict, FLUSH_CYCLES=2, `redirect_ready`=1:
  - Trigger at T with target 0x0000_1040.
  - Expect `backend_flush` at T+1..T+2, `rat_restore` at T+1, `redirect_valid` at T+3 with `redirect_pc`=0x1040.
  - Expect DRAIN at T+4, `commit_stall` low at T+5.
- Redirect backpressure:
  - Hold `redirect_ready=0` for 5 cycles in REDIRECT.
  - Expect `redirect_valid` and `redirect_pc` stable throughout, `commit_stall` high throughout, and exit 2 cycles after `ready`.
- Non-triggers:
  - Commit a correctly predicted branch.
  - Commit a non-control uop with `commit_mispredict=1`.
  - Expect state remains IDLE and no flush.
- Reset mid-recovery:
  - Assert `rst=0` during FLUSH cycle 2.
  - Expect IDLE and all outputs 0 next cycle.
  - A new trigger afterwards behaves as in the basic mispredict scenario.
- Perf counters, with `BR_PERF_CNT_EN`:
  - Run 7 control commits, 3 of them mispredicted.
  - Expect `perf_br_cnt`=7 and `perf_mp_cnt`=3.
  - Preload near 0xFFFFFFFF and confirm wrap to 0.
  - Without the macro, both outputs read 0.
